// File: rtl/aludec_pkg.sv
// Shared types and constants for the ALU control decoder and its
// multiply/divide unit.
//   alucontrol_t : 4-bit ALU operation select driven to the datapath
//   aluop_e      : non-R-type ALU op classes supplied by maindec
//   FUNCT_*      : R-type funct codes recognised by the decoder
//   mdu_state_t  : iterative multiply/divide sequencer states
package aludec_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_LUI  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_BLEZ = 4'b1010,
    ALU_SRLV = 4'b1011,
    ALU_SRL  = 4'b1100,
    ALU_SLLV = 4'b1101
  } alucontrol_t;

  typedef enum logic [2:0] {
    AOP_ADD  = 3'd0,
    AOP_SUB  = 3'd1,
    AOP_BLEZ = 3'd2,
    AOP_OR   = 3'd3,
    AOP_LUI  = 3'd4,
    AOP_XOR  = 3'd5,
    AOP_SLT  = 3'd6,
    AOP_AND  = 3'd7
  } aluop_e;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : launch mult/div (only honoured in IDLE)
//   op_div, op_signed   : operation select for the launched op
//   a, b                : operands (multiplicand/dividend, multiplier/divisor)
//   wr_hi, wr_lo, wdata : direct HI/LO writes (mthi/mtlo)
//   busy, done          : sequencer not idle / result being committed
//   hi, lo              : architectural HI/LO
// Operands are converted to magnitudes up front, the loop runs unsigned
// for WIDTH cycles, and the sign is applied in FIX while HI/LO are written.
module mdu_core
  import aludec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_acc, r_q, r_m;
  logic             r_div, r_neg_q, r_neg_r, r_dz;

  logic [WIDTH:0]     w_msum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_pmag, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    return (sgn && (v < 0)) ? -v : v;
  endfunction

  // Step arithmetic: r_acc is the running high half (mult) or partial
  // remainder (div); r_q holds the multiplier bits / collects quotient bits.
  always_comb begin
    w_msum  = {1'b0, r_acc} + {1'b0, r_m};
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_m};
    w_pmag  = {r_acc, r_q};
    w_prod  = r_neg_q ? -w_pmag : w_pmag;
    // Divide-by-zero leaves the dividend magnitude in r_acc, so the
    // remainder sign fix restores the original dividend; only the
    // quotient needs forcing to all ones.
    w_quo   = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
    w_rem   = r_neg_r ? -r_acc : r_acc;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start) r_cnt <= '0;
      else if (r_state == RUN)      r_cnt <= r_cnt + 1'b1;
      if (r_state == FIX) begin
        r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
      end else begin
        if (wr_hi) r_hi <= wdata;
        if (wr_lo) r_lo <= wdata;
      end
    end
  end

  // Working registers carry no reset; they are always loaded on start.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_acc   <= '0;
      r_q     <= mag(a, op_signed);
      r_m     <= mag(b, op_signed);
      r_div   <= op_div;
      r_neg_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= op_signed & a[WIDTH-1];
      r_dz    <= op_div & (b == '0);
    end else if (r_state == RUN) begin
      if (r_div) begin
        // Restoring division: keep the difference only when it is non-negative.
        if (!w_diff[WIDTH]) begin
          r_acc <= w_diff[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end else if (r_q[0]) begin
        r_acc <= w_msum[WIDTH:1];
        r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
      end else begin
        r_acc <= {1'b0, r_acc[WIDTH-1:1]};
        r_q   <= {r_acc[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == FIX);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/aludec_mdu.sv
// ALU control decoder with integrated iterative multiply/divide unit.
//   clk, reset         : clock, asynchronous active-low reset
//   en                 : instruction in decode is valid
//   aluop, funct       : op class from maindec, instr[5:0]
//   srca, srcb         : rs / rt operand values
//   alucontrol         : ALU operation select (pure decode, ignores reset)
//   illegal            : undecodable R-type funct while en
//   stall              : MDU instruction blocked by an in-flight op
//   mdu_rd, mdu_result : mfhi/mflo accepted and the HI/LO value to write back
//   busy, done         : MDU sequencer status
module aludec_mdu
  import aludec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AOP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [AOP_W-1:0] aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [3:0]       alucontrol,
  output logic             illegal,
  output logic             stall,
  output logic             mdu_rd,
  output logic [WIDTH-1:0] mdu_result,
  output logic             busy,
  output logic             done
);

  localparam int AL_W = AOP_W - 1;

  alucontrol_t      w_alu;
  logic             w_known, w_mdu_f, w_rtype, w_accept;
  logic             w_start, w_wr_hi, w_wr_lo;
  logic [AL_W-1:0]  w_aop_lo;
  logic [WIDTH-1:0] w_hi, w_lo;

  assign w_rtype  = aluop[AOP_W-1];
  assign w_aop_lo = aluop[AOP_W-2:0];

  always_comb begin
    w_alu   = ALU_AND;
    w_known = 1'b1;
    w_mdu_f = 1'b0;
    if (!w_rtype) begin
      case (w_aop_lo)
        AL_W'(AOP_ADD):  w_alu = ALU_ADD;
        AL_W'(AOP_SUB):  w_alu = ALU_SUB;
        AL_W'(AOP_BLEZ): w_alu = ALU_BLEZ;
        AL_W'(AOP_OR):   w_alu = ALU_OR;
        AL_W'(AOP_LUI):  w_alu = ALU_LUI;
        AL_W'(AOP_XOR):  w_alu = ALU_XOR;
        AL_W'(AOP_SLT):  w_alu = ALU_SLT;
        AL_W'(AOP_AND):  w_alu = ALU_AND;
        default:         w_alu = ALU_ADD;
      endcase
    end else begin
      casez (funct)
        FUNCT_SLL:  w_alu = ALU_SLL;
        FUNCT_SRL:  w_alu = ALU_SRL;
        FUNCT_SLLV: w_alu = ALU_SLLV;
        FUNCT_SRLV: w_alu = ALU_SRLV;
        FUNCT_ADD:  w_alu = ALU_ADD;
        FUNCT_SUB:  w_alu = ALU_SUB;
        FUNCT_AND:  w_alu = ALU_AND;
        FUNCT_OR:   w_alu = ALU_OR;
        FUNCT_SLT:  w_alu = ALU_SLT;
        // mfhi/mthi/mflo/mtlo and mult/multu/div/divu
        6'b01?0??: begin
          w_alu   = ALU_ADD;
          w_mdu_f = 1'b1;
        end
        default:    w_known = 1'b0;
      endcase
    end
  end

  assign alucontrol = w_alu;
  assign illegal    = reset & en & w_rtype & ~w_known;
  assign stall      = reset & en & w_mdu_f & busy;
  assign w_accept   = reset & en & w_mdu_f & ~busy;

  // funct[3] separates mult/div from HI/LO moves; funct[1] picks div or LO,
  // funct[0] marks unsigned (mult/div) or move-to (HI/LO).
  assign w_start    = w_accept & funct[3];
  assign w_wr_hi    = w_accept & ~funct[3] & funct[0] & ~funct[1];
  assign w_wr_lo    = w_accept & ~funct[3] & funct[0] & funct[1];
  assign mdu_rd     = w_accept & ~funct[3] & ~funct[0];
  assign mdu_result = mdu_rd ? (funct[1] ? w_lo : w_hi) : '0;

  mdu_core #(
    .WIDTH(WIDTH)
  ) u_mdu_core (
    .clk       (clk),
    .rst_n     (reset),
    .start     (w_start),
    .op_div    (funct[1]),
    .op_signed (~funct[0]),
    .a         (srca),
    .b         (srcb),
    .wr_hi     (w_wr_hi),
    .wr_lo     (w_wr_lo),
    .wdata     (srca),
    .busy      (busy),
    .done      (done),
    .hi        (w_hi),
    .lo        (w_lo)
  );

endmodule
